// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: four-core request bundle plus data-memory port for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          req_rd;
    logic [3:0]          req_wr;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_wdata;
    logic [3:0]          ack;
    logic [DATA_W-1:0]   core_rdata;
    logic                busy;
    logic [1:0]          grant_id;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        output ack, core_rdata, busy, grant_id, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        input  ack, core_rdata, busy, grant_id, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-core single-port memory arbiter; MEM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    state_t              state, state_nxt;
    logic [3:0]          req;
    logic [1:0]          win;
    logic [1:0]          gid;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [1:0]          last_grant;
    logic [1:0]          idx;
`endif
    assign req            = bus.req_rd | bus.req_wr;
    assign bus.grant_id   = gid;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    assign bus.core_rdata = rdata;
    // winner selection; the later (higher-priority) candidate in the scan overrides earlier ones
    always_comb begin
        win = 2'd0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) win = req[k] ? 2'(k) : win;
`else
        idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant + 2'(k);
            win = req[idx] ? idx : win;
        end
`endif
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        bus.busy    = state != IDLE;
        bus.mem_en  = state == ACCESS;
        bus.mem_we  = (state == ACCESS) && lat_we;
        bus.ack     = (state == DONE) ? (4'b0001 << gid) : 4'b0000;
        case (state)
            IDLE:    state_nxt = |req ? ACCESS : IDLE;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // latch the winning request at grant and capture load data one cycle after the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid       <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant <= 2'd3;
`endif
        end else begin
            if (state == IDLE && |req) begin
                gid       <= win;
                lat_we    <= bus.req_wr[win];
                lat_addr  <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
                lat_wdata <= bus.req_wdata[int'(win)*DATA_W +: DATA_W];
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_grant <= win;
`endif
            end
            if (state == CAPTURE && !lat_we) rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; core count fixed at 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_rd  input  4  per-core load request; bit i = core i.
REQ-005 req_wr  input  4  per-core store request.
REQ-006 req_addr  input  4*ADDR_W  per-core address; core i in slice [i*ADDR_W +: ADDR_W].
REQ-007 req_wdata  input  4*DATA_W  per-core store data, sliced the same way.
REQ-008 ack  output  4  one-hot, one-cycle completion pulse to the granted core.
REQ-009 core_rdata  output  DATA_W  registered load data; valid only while ack is nonzero.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  2  index of the core owning the current transaction.
REQ-012 mem_en, mem_we  output  1 each  data-memory enable and write enable.
REQ-013 mem_addr, mem_wdata  output  ADDR_W, DATA_W  registered memory address and write data.
REQ-014 mem_rdata  input  DATA_W  memory read data; synchronous, valid one cycle after mem_en.

Function
REQ-015 Core i requests when req_rd[i] or req_wr[i] is high; if both are high, the request is a store.
REQ-016 FSM states: IDLE, ACCESS, CAPTURE, DONE; each non-IDLE state lasts exactly one cycle.
REQ-017 IDLE: if no request, stay. Otherwise pick a winner by round-robin, latch grant_id, addr, wdata and type, and go to ACCESS.
REQ-018 Round-robin search starts at (last_grant+1) mod 4, wraps 3->0, and updates last_grant on each grant.
REQ-019 ACCESS: mem_en=1, mem_we=1 for a store, memory outputs come from the latched values; next state is CAPTURE.
REQ-020 CAPTURE: mem_en=0. For a load, core_rdata <= mem_rdata; for a store, core_rdata holds. Next state is DONE.
REQ-021 DONE: ack[grant_id]=1 for exactly this cycle; next state is IDLE.
REQ-022 Latency from the IDLE cycle that grants to ack is 3 cycles; one transaction takes 4 cycles.
REQ-023 Requester inputs after the grant cycle are ignored until that core's ack.
REQ-024 A requester SHALL hold its request until ack and drop it on the cycle after ack; a request still high in IDLE after DONE is a new transaction.
REQ-025 Requests arriving during busy are not lost; they are arbitrated in the next IDLE cycle.
REQ-026 mem_en is never high outside ACCESS; at most one ack bit is ever high.

Reset
REQ-027 rst_n low forces, immediately and without clk: state=IDLE, last_grant=3 (core 0 wins first), ack=0, core_rdata=0, busy=0, grant_id=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during ACCESS, CAPTURE or DONE abandons the transaction without an ack; a write already issued in ACCESS may have reached memory.
REQ-029 After rst_n rises, the first arbitration happens on the first rising clk edge.

Configuration
REQ-030 Macro MEM_ARB_FIXED_PRIO_EN: when defined, the winner is always the lowest-index requesting core and last_grant is unused.
REQ-031 Without MEM_ARB_FIXED_PRIO_EN, round-robin per REQ-018 applies; all other behaviour is identical in both modes.

Verification
REQ-032 Single load: core 2 req_rd, addr 0x10, memory holds 0xDEADBEEF -> mem_en one cycle with we=0, addr 0x10; ack=4'b0100 three cycles after grant; core_rdata=0xDEADBEEF.
REQ-033 Single store: core 1 req_wr, addr 0x20, wdata 0x12345678 -> mem_en=mem_we=1 for one cycle with those values; ack=4'b0010; core_rdata unchanged.
REQ-034 All 4 cores request continuously after reset, round-robin build -> grant order 0,1,2,3,0; acks 4 cycles apart.
REQ-035 Same stimulus with MEM_ARB_FIXED_PRIO_EN defined, each core dropping its request after ack -> grant order 0,1,2,3.
REQ-036 rst_n pulsed low mid-CAPTURE of a core 3 load -> no ack; all outputs at reset values asynchronously; a held core 3 request is granted after reset release.
REQ-037 Core 0 drives req_rd and req_wr together, and changes addr after grant -> treated as a store to the originally latched address.
